mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter and sequencer for the single-ported memory unit (10-bit word address, 32-bit data, synchronous-read RAM plus memory-mapped I/O ports). It time-shares the unit between requester 0 (instruction fetch) and requester 1 (load/store), using round-robin on contention. It issues one access at a time, drives the memory unit's `addr`/`write_en`/`data_in`, and returns read data with a one-cycle `rvalid` pulse.

## Interface
- `READ_LAT`, default 1: cycles from address presented to `mem_rdata` valid. Legal range 1..4.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req[1:0]`  in  2  access request, one bit per requester.
- `we[1:0]`  in  2  per-requester write flag (1 = write, 0 = read).
- `addr0`, `addr1`  in  10 each  per-requester word address.
- `wdata0`, `wdata1`  in  32 each  per-requester write data.
- `gnt[1:0]`  out  2  one-cycle pulse: the request is issued to memory this cycle.
- `rvalid[1:0]`  out  2  one-cycle pulse: `rdata` for that requester is valid.
- `rdata0`, `rdata1`  out  32 each  registered read data; holds until the next read for the same requester.
- `busy`  out  1  high whenever state is not IDLE.
- `mem_addr`  out  10  drives the memory unit's address.
- `mem_write_en`  out  1  drives the memory unit's write enable.
- `mem_wdata`  out  32  drives the memory unit's write data.
- `mem_rdata`  in  32  memory unit read data.

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE: if any `req` bit is high at the clock edge, the arbiter selects a winner, captures that requester's `we`/addr/wdata into internal registers, and moves to ISSUE. Otherwise it stays in IDLE.
- Arbitration:
  - A single active request always wins.
  - If both are active, the requester not served last wins.
  - The `last` pointer resets to 1, so requester 0 wins the first tie.
  - `last` updates on capture.
- Commit on capture: once captured, the transaction completes even if `req` drops. Requesters must hold `req` and their fields stable until they see `gnt`.
- ISSUE (exactly 1 cycle):
  - `mem_addr` and `mem_wdata` come from the captured registers.
  - `mem_write_en` equals the captured `we`.
  - `gnt[winner]` = 1.
  - Write: next state is IDLE.
  - Read: next state is WAIT, with counter loaded to READ_LAT-1.
- WAIT: `mem_addr` holds the captured address and `mem_write_en` = 0. The counter decrements each cycle. On the cycle where the counter is 0:
  - `mem_rdata` is registered into `rdata<winner>`.
  - `rvalid[winner]` is set; it is registered, so it is high during the following cycle.
  - Next state is IDLE.
- `mem_write_en` is 1 only in ISSUE of a write. No other cycle may write memory or the I/O ports.
- In IDLE, `mem_addr`/`mem_wdata` hold their last driven values.
- At most one `gnt` bit and one `rvalid` bit are high in any cycle.
- A requester's `rvalid` may coincide with a new capture in IDLE, including a capture for that same requester.

## Timing
- Reset values:
  - state IDLE, `last` = 1, counter 0.
  - `gnt`, `rvalid`, `busy`, `mem_write_en` = 0.
  - `mem_addr` = 0, `mem_wdata` = 0, `rdata0` = `rdata1` = 0.
- Request sampled at edge ending cycle N:
  - `gnt` in cycle N+1.
  - Write lands at the edge ending N+1; next capture possible at edge ending N+2.
  - Read `rvalid` in cycle N+2+READ_LAT (N+3 for READ_LAT=1).
- Throughput: a write occupies 2 cycles; a read occupies 2+READ_LAT cycles, excluding the `rvalid` cycle, which overlaps IDLE.
- Reset asserted mid-transaction (ISSUE or WAIT):
  - All outputs go to reset values immediately.
  - The pending transaction is dropped.
  - No `gnt` or `rvalid` is produced for it after reset releases.

## Test plan
- Reset: assert `rst` with random inputs -> all outputs at reset values, `busy` = 0, no `mem_write_en` pulse.
- Single write: `req`=01, `we0`=1, `addr0`=0x3FC, `wdata0`=0xDEADBEEF -> `gnt0` pulse one cycle later; in that same cycle `mem_write_en`=1, `mem_addr`=0x3FC, `mem_wdata`=0xDEADBEEF. `busy` clears the next cycle.
- Single read: write 0x12345678 to 0x010 via requester 1, then read 0x010 from requester 1 -> `rvalid1` exactly 3 cycles after the request is sampled (READ_LAT=1), `rdata1`=0x12345678 and held afterwards. `rvalid0` stays 0.
- Contention: both requesters hold reads continuously -> grants alternate 0,1,0,1. Never two `gnt` bits in one cycle; each `rvalid` matches its requester's address.
- Early drop: `req0` high for only the sampling cycle -> transaction still completes with `gnt0` and, for a read, `rvalid0`.
- Reset in WAIT: read issued, `rst` pulsed during WAIT -> no `rvalid`, `rdata` = 0, and the next request after release is serviced normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter/sequencer sharing one synchronous-read
// memory unit between requester 0 (fetch) and requester 1 (load/store).
// Ports:
//   clk, rst (async, active-high)
//   req[1:0], we[1:0], addr0/1[9:0], wdata0/1[31:0]  requester side
//   gnt[1:0], rvalid[1:0], rdata0/1[31:0], busy        requester side
//   mem_addr[9:0], mem_write_en, mem_wdata[31:0]       memory drive
//   mem_rdata[31:0]                                    memory read data
// All outputs are registered.
module mem_arbiter #(
   parameter int READ_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req,
   input  logic [1:0]  we,
   input  logic [9:0]  addr0,
   input  logic [9:0]  addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic [1:0]  gnt,
   output logic [1:0]  rvalid,
   output logic [31:0] rdata0,
   output logic [31:0] rdata1,
   output logic        busy,
   output logic [9:0]  mem_addr,
   output logic        mem_write_en,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   localparam logic [1:0] LAT_M1 = 2'(READ_LAT - 1);

   state_t      state_q, state_d;
   logic        last_q, last_d;
   logic        win_q, win_d;
   logic        we_q, we_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [1:0]  gnt_q, gnt_d;
   logic [1:0]  rvalid_q, rvalid_d;
   logic [31:0] rdata0_q, rdata0_d;
   logic [31:0] rdata1_q, rdata1_d;
   logic        busy_q, busy_d;
   logic [9:0]  addr_q, addr_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] wdata_q, wdata_d;
   logic        sel;

   // Lone request wins; on a tie the requester not served last wins.
   always_comb begin
      sel = 1'b0;
      if (req == 2'b10)
         sel = 1'b1;
      else if (req == 2'b11)
         sel = ~last_q;
   end

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      win_d    = win_q;
      we_d     = we_q;
      cnt_d    = cnt_q;
      gnt_d    = 2'b00;
      rvalid_d = 2'b00;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      addr_d   = addr_q;
      mem_we_d = 1'b0;
      wdata_d  = wdata_q;
      unique case (state_q)
         IDLE: begin
            // Capture straight into the memory-drive registers so the
            // access is presented in the ISSUE cycle itself.
            if (|req) begin
               win_d      = sel;
               last_d     = sel;
               we_d       = we[sel];
               addr_d     = sel ? addr1 : addr0;
               wdata_d    = sel ? wdata1 : wdata0;
               gnt_d[sel] = 1'b1;
               mem_we_d   = we[sel];
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            if (we_q) begin
               state_d = IDLE;
            end else begin
               state_d = WAIT;
               cnt_d   = LAT_M1;
            end
         end
         WAIT: begin
            if (cnt_q == 2'd0) begin
               rvalid_d[win_q] = 1'b1;
               if (win_q)
                  rdata1_d = mem_rdata;
               else
                  rdata0_d = mem_rdata;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         last_q   <= 1'b1;
         win_q    <= 1'b0;
         we_q     <= 1'b0;
         cnt_q    <= 2'd0;
         gnt_q    <= 2'b00;
         rvalid_q <= 2'b00;
         rdata0_q <= 32'd0;
         rdata1_q <= 32'd0;
         busy_q   <= 1'b0;
         addr_q   <= 10'd0;
         mem_we_q <= 1'b0;
         wdata_q  <= 32'd0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         win_q    <= win_d;
         we_q     <= we_d;
         cnt_q    <= cnt_d;
         gnt_q    <= gnt_d;
         rvalid_q <= rvalid_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         busy_q   <= busy_d;
         addr_q   <= addr_d;
         mem_we_q <= mem_we_d;
         wdata_q  <= wdata_d;
      end
   end

   assign gnt          = gnt_q;
   assign rvalid       = rvalid_q;
   assign rdata0       = rdata0_q;
   assign rdata1       = rdata1_q;
   assign busy         = busy_q;
   assign mem_addr     = addr_q;
   assign mem_write_en = mem_we_q;
   assign mem_wdata    = wdata_q;

endmodule
